// File: rtl/multiplicador_verificador_7bits.sv
// -----------------------------------------------------------------------------
// multiplicador_verificador_7bits
//
// Sequential shift-add multiplier that rebuilds a dividend from the result of a
// restoring division: P = Q*B + R. The rebuilt value is compared against a
// reference dividend, which lets a design or bench check its divider on the fly.
// One multiplier bit is consumed per clock, so the latency is a fixed WIDTH
// cycles from the accepting edge to done.
//
// Ports
//   clk    in   1          system clock, rising edge
//   rst    in   1          synchronous, active-high reset
//   start  in   1          request; only looked at in IDLE or DONE
//   Q_in   in   WIDTH      quotient (multiplier)
//   B_in   in   WIDTH      divisor (multiplicand)
//   R_in   in   WIDTH      remainder (addend, preloaded into the accumulator)
//   A_ref  in   WIDTH      expected dividend for the compare
//   P      out  2*WIDTH    registered result Q*B+R
//   done   out  1          result valid; held until the next accepted start
//   match  out  1          P equals zero-extended A_ref; valid while done=1
//   busy   out  1          high while the multiplication runs
// -----------------------------------------------------------------------------
module multiplicador_verificador_7bits #(
  parameter int WIDTH = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   Q_in,
  input  logic [WIDTH-1:0]   B_in,
  input  logic [WIDTH-1:0]   R_in,
  input  logic [WIDTH-1:0]   A_ref,
  output logic [2*WIDTH-1:0] P,
  output logic               done,
  output logic               match,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  q_sh;      // multiplier, consumed LSB first
  logic [PW-1:0]     b_sh;      // multiplicand, shifted up one place per step
  logic [PW-1:0]     acc;       // running sum, starts at R
  logic [WIDTH-1:0]  a_ref_q;   // reference dividend captured at accept
  logic [CW-1:0]     cnt;

  logic [PW-1:0]     acc_next;
  logic              accept;

  // Accumulator value after the current step; used both to advance acc and,
  // on the last step, to load P and evaluate match in the same edge.
  // NOTE: every signal driven here gets a value before any condition, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    acc_next = acc;
    if (q_sh[0]) begin
      acc_next = acc + b_sh;
    end
  end

  assign accept = start && (state == IDLE || state == DONE);

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      q_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      a_ref_q <= '0;
      cnt     <= '0;
      P       <= '0;
      done    <= 1'b0;
      match   <= 1'b0;
      busy    <= 1'b0;
    end else if (accept) begin
      q_sh    <= Q_in;
      b_sh    <= {{WIDTH{1'b0}}, B_in};
      acc     <= {{WIDTH{1'b0}}, R_in};
      a_ref_q <= A_ref;
      cnt     <= '0;
      done    <= 1'b0;
      match   <= 1'b0;
      busy    <= 1'b1;
      state   <= RUN;
    end else if (state == RUN) begin
      acc  <= acc_next;
      q_sh <= q_sh >> 1;
      b_sh <= b_sh << 1;
      cnt  <= cnt + 1'b1;
      if (cnt == LAST_CNT) begin
        // The last step's sum goes straight to P rather than waiting a cycle.
        P     <= acc_next;
        match <= (acc_next == {{WIDTH{1'b0}}, a_ref_q});
        done  <= 1'b1;
        busy  <= 1'b0;
        state <= DONE;
      end
    end
  end

endmodule

// File: tb/tb_multiplicador_verificador_7bits.sv
// -----------------------------------------------------------------------------
// Bench for multiplicador_verificador_7bits. A transaction-level model tracks
// what busy/done/P/match must be on every cycle (product computed with plain
// arithmetic, completion scheduled WIDTH cycles after acceptance); a compare
// process checks the DUT against it at every falling edge. Directed vectors
// carry hand-computed literal results as well.
// -----------------------------------------------------------------------------
module tb_multiplicador_verificador_7bits;

  localparam int WIDTH = 7;
  localparam int PW    = 2 * WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] q_in, b_in, r_in, a_ref;
  logic [PW-1:0]    p;
  logic             done, match, busy;

  int checks = 0;
  int errors = 0;

  multiplicador_verificador_7bits #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .Q_in  (q_in),
    .B_in  (b_in),
    .R_in  (r_in),
    .A_ref (a_ref),
    .P     (p),
    .done  (done),
    .match (match),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_busy, m_done, m_p, m_match, m_left;
  int pend_p, pend_match;
  bit model_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_p = 0; m_match = 0; m_left = 0;
      model_valid = 1'b1;
    end else if (start && m_busy == 0) begin
      pend_p     = int'(q_in) * int'(b_in) + int'(r_in);
      pend_match = (pend_p == int'(a_ref)) ? 1 : 0;
      m_busy = 1; m_done = 0; m_match = 0; m_left = WIDTH;
    end else if (m_busy != 0) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0; m_done = 1; m_p = pend_p; m_match = pend_match;
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("cyc_busy", 32'(busy), 32'(m_busy));
      check("cyc_done", 32'(done), 32'(m_done));
      check("cyc_p",    32'(p),    32'(m_p));
      if (m_done != 0) check("cyc_match", 32'(match), 32'(m_match));
    end
  end

  // ---------------- stimulus ----------------
  task automatic apply_start(input int q, input int b, input int r, input int a);
    @(negedge clk);
    q_in = WIDTH'(q); b_in = WIDTH'(b); r_in = WIDTH'(r); a_ref = WIDTH'(a);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_done_low", 32'(done), 32'd0);
  endtask

  // Waits for done, counting falling edges after the accepting edge.
  task automatic wait_done(input string name, input int exp_p, input int exp_match);
    int lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'd7);
    check({name, "_p"},       32'(p),   32'(exp_p));
    check({name, "_match"},   32'(match), 32'(exp_match));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b1;   // reset must win over start
    q_in = '0; b_in = '0; r_in = '0; a_ref = '0;
    repeat (2) @(negedge clk);
    start = 1'b0;
    check("rst_p", 32'(p), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_match", 32'(match), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: basic, latency
    apply_start(3, 2, 1, 7);    wait_done("t1", 7, 1);
    repeat (3) @(negedge clk);
    check("t1_hold_p", 32'(p), 32'd7);
    check("t1_hold_done", 32'(done), 32'd1);

    // 2
    apply_start(7, 7, 1, 50);   wait_done("t2a", 50, 1);
    apply_start(9, 13, 10, 127); wait_done("t2b", 127, 1);

    // 3: boundaries
    apply_start(127, 127, 127, 0); wait_done("t3_ones", 16256, 0);
    apply_start(0, 5, 4, 4);       wait_done("t3_q0", 4, 1);
    apply_start(6, 0, 9, 10);      wait_done("t3_b0", 9, 0);
    apply_start(2, 3, 100, 106);   wait_done("t3_r_big", 106, 1);

    // 4: start during RUN ignored, late input changes ignored
    apply_start(19, 5, 4, 99);
    @(negedge clk);
    q_in = 7'd1; b_in = 7'd1; r_in = 7'd0; a_ref = 7'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t4_busy_mid", 32'(busy), 32'd1);
    begin
      int lat = 2;
      while (!done && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      check("t4_latency", 32'(lat), 32'd7);
    end
    check("t4_p", 32'(p), 32'd99);
    check("t4_match", 32'(match), 32'd1);

    // 5: reset mid-RUN aborts
    apply_start(10, 10, 3, 103);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_p", 32'(p), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    check("t5_no_done", 32'(done), 32'd0);
    apply_start(11, 11, 0, 121); wait_done("t5_restart", 121, 1);

    // 6: back-to-back start from DONE
    apply_start(5, 6, 2, 31); wait_done("t6a", 32, 0);
    apply_start(12, 10, 7, 127); wait_done("t6b", 127, 1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
